time_keeper: RTL and testbench
==============================

TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock (50 MHz); all state on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port sec_clk, input, 1 bit: divided 1 Hz square wave from the clock divider, asynchronous to clk logic.
REQ-004 SHALL have port pause, input, 1 bit: high = ignore second ticks (ticks dropped, not queued).
REQ-005 SHALL have port set_valid, input, 1 bit: time-set request.
REQ-006 SHALL have port set_field, input, 2 bits: 0 = seconds, 1 = minutes, 2 = hours, 3 = reserved.
REQ-007 SHALL have port set_value, input, 8 bits: packed BCD (tens[7:4], units[3:0]).
REQ-008 SHALL have port set_ready, output, 1 bit: block can accept a set request.
REQ-009 SHALL have port set_err, output, 1 bit: one-cycle pulse, accepted request rejected.
REQ-010 SHALL have ports seconds_bcd, minutes_bcd, hours_bcd, output, 8 bits each: current time, packed BCD.
REQ-011 SHALL have port sec_pulse, output, 1 bit: one-cycle pulse per applied second tick.

Function
REQ-012 SHALL pass sec_clk through two synchroniser flops (s1, s2) plus one history flop (s3); tick = s2 & ~s3.
REQ-013 SHALL, when sec_clk is first sampled high at edge N, present the incremented time and sec_pulse = 1 after edge N+2, sec_pulse low again after edge N+3.
REQ-014 SHALL produce exactly one tick per sec_clk rising edge; falling edges and static levels produce none.
REQ-015 SHALL count seconds 00..59, minutes 00..59, hours 00..23, all in BCD; units digit wraps 9->0 and increments tens.
REQ-016 SHALL ripple carries in the same cycle: seconds 59->00 advances minutes; minutes 59->00 with seconds carry advances hours; 23:59:59 -> 00:00:00 in one tick.
REQ-017 SHALL, when pause = 1, drop the tick: no count change, sec_pulse stays 0.
REQ-018 SHALL drive set_ready = 1 whenever out of reset, except the single cycle immediately after an accepted request (set_ready = 0 that cycle).
REQ-019 SHALL accept a request when set_valid & set_ready at a rising edge; new value visible after that edge.
REQ-020 SHALL reject (no update, set_err = 1 for one cycle after the edge) when set_field = 3, any digit > 9, or the value exceeds the field maximum (59/59/23).
REQ-021 SHALL, on simultaneous accepted set and tick, load the set field with set_value, advance lower fields normally, drop any carry into the set field, and propagate no carry out of it; sec_pulse still asserts.
REQ-022 SHALL, on rejected set coincident with tick, apply the tick normally.

Reset
REQ-023 SHALL, while reset = 0, hold all counters at 00, sec_pulse = 0, set_err = 0, set_ready = 0, and s1/s2/s3 = 0.
REQ-024 SHALL, if sec_clk is high at reset release, generate exactly one tick (history flop resets to 0).
REQ-025 SHALL, on reset asserted mid-operation, clear state immediately without waiting for clk.

Structure
REQ-026 SHALL take from shared package clock_pkg the constants SEC_MAX = 8'h59, MIN_MAX = 8'h59, HR_MAX = 8'h23 and the set_field encodings.
REQ-027 SHALL instantiate sub-module bcd_counter three times (parameter: BCD maximum; ports: inc, load, load_value, value, carry_out).
REQ-028 SHALL keep the synchroniser and edge detect inside time_keeper; no other clock domains or clocks.

Verification
REQ-029 Reset low with sec_clk high, release -> one sec_pulse; time reads 00:00:01.
REQ-030 Set hours 23, minutes 59, seconds 59; one sec_clk rise -> 00:00:00 after edge N+2, sec_pulse one cycle.
REQ-031 Set field 2, value 8'h24 -> set_err pulse, hours unchanged; value 8'h1A -> set_err, no update.
REQ-032 Time 00:00:59, minutes set to 8'h30 on tick cycle -> 00:30:00 (carry dropped).
REQ-033 pause = 1 across three sec_clk rises -> no count change, no sec_pulse; pause = 0 -> next rise increments by exactly 1.
REQ-034 Back-to-back set_valid for 2 cycles -> first accepted, set_ready = 0 next cycle, second held and accepted a cycle later.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg -- shared constants and helpers for the time-of-day keeper.
//   SEC_MAX / MIN_MAX / HR_MAX : largest legal packed-BCD value per field
//   set_field_e                : encoding of the set_field request port
//   bcd_in_range()             : true when a packed-BCD byte has legal digits
//                                and does not exceed the given field maximum
package clock_pkg;

  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] HR_MAX  = 8'h23;

  typedef enum logic [1:0] {
    FIELD_SEC  = 2'd0,
    FIELD_MIN  = 2'd1,
    FIELD_HR   = 2'd2,
    FIELD_RSVD = 2'd3
  } set_field_e;

  // With both digits legal, packed BCD orders the same as its numeric
  // value, so a plain unsigned compare against the maximum is enough.
  function automatic logic bcd_in_range(input logic [7:0] value,
                                        input logic [7:0] max);
    return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// bcd_counter -- two-digit packed-BCD counter, 00..MAX, with parallel load.
//   clk        : system clock
//   reset      : asynchronous active-low reset, clears the count to 00
//   inc        : advance by one this cycle (wraps MAX -> 00)
//   load       : overwrite with load_value; wins over inc
//   load_value : packed-BCD value to load
//   value      : current count, packed BCD
//   carry_out  : combinational, high when this cycle's inc wraps the count;
//                a load suppresses it so nothing ripples out of a loaded field
module bcd_counter #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic [7:0] value,
  output logic       carry_out
);

  logic [7:0] value_q;
  logic [7:0] value_d;
  logic       at_max;

  assign at_max = (value_q == MAX);

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_value;
    end else if (inc) begin
      if (at_max) begin
        value_d = 8'h00;
      end else if (value_q[3:0] == 4'd9) begin
        value_d = {value_q[7:4] + 4'd1, 4'd0};
      end else begin
        value_d = {value_q[7:4], value_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= 8'h00;
    end else begin
      value_q <= value_d;
    end
  end

  assign value     = value_q;
  assign carry_out = inc & ~load & at_max;

endmodule

// File: rtl/time_keeper.sv
// time_keeper -- BCD hours:minutes:seconds keeper driven by an external 1 Hz
// square wave, with a single-field time-set port.
//   clk          : 50 MHz system clock, all state on its rising edge
//   reset        : asynchronous active-low reset
//   sec_clk      : 1 Hz square wave, asynchronous to clk
//   pause        : high drops second ticks (they are not queued)
//   set_valid    : time-set request
//   set_field    : 0 seconds, 1 minutes, 2 hours, 3 reserved
//   set_value    : packed-BCD value for the selected field
//   set_ready    : low only in the cycle after an accepted request
//   set_err      : one-cycle pulse when an accepted request is rejected
//   seconds_bcd / minutes_bcd / hours_bcd : current time, packed BCD
//   sec_pulse    : one-cycle pulse per applied second tick
module time_keeper
  import clock_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_clk,
  input  logic       pause,
  input  logic       set_valid,
  input  logic [1:0] set_field,
  input  logic [7:0] set_value,
  output logic       set_ready,
  output logic       set_err,
  output logic [7:0] seconds_bcd,
  output logic [7:0] minutes_bcd,
  output logic [7:0] hours_bcd,
  output logic       sec_pulse
);

  logic       s1_q, s2_q, s3_q;
  logic       tick;
  logic       set_ready_q, set_err_q, sec_pulse_q;
  logic       accept, set_ok;
  logic       load_sec, load_min, load_hr;
  logic [7:0] field_max;
  logic       sec_carry, min_carry, hr_carry_unused;
  set_field_e field;

  // Two-flop synchroniser plus a history flop for rising-edge detection.
  // s3 resets to 0 so a sec_clk already high at reset release still
  // produces exactly one tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sec_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick = s2_q & ~s3_q & ~pause;

  assign field  = set_field_e'(set_field);
  assign accept = set_valid & set_ready_q;

  always_comb begin
    field_max = SEC_MAX;
    case (field)
      FIELD_MIN: field_max = MIN_MAX;
      FIELD_HR:  field_max = HR_MAX;
      default:   field_max = SEC_MAX;
    endcase
  end

  assign set_ok   = accept & (field != FIELD_RSVD) & bcd_in_range(set_value, field_max);
  assign load_sec = set_ok & (field == FIELD_SEC);
  assign load_min = set_ok & (field == FIELD_MIN);
  assign load_hr  = set_ok & (field == FIELD_HR);

  // Carries ripple combinationally so 23:59:59 -> 00:00:00 in one tick; a
  // loaded field swallows any incoming carry and emits none.
  bcd_counter #(.MAX(SEC_MAX)) u_sec (
    .clk        (clk),
    .reset      (reset),
    .inc        (tick),
    .load       (load_sec),
    .load_value (set_value),
    .value      (seconds_bcd),
    .carry_out  (sec_carry)
  );

  bcd_counter #(.MAX(MIN_MAX)) u_min (
    .clk        (clk),
    .reset      (reset),
    .inc        (sec_carry),
    .load       (load_min),
    .load_value (set_value),
    .value      (minutes_bcd),
    .carry_out  (min_carry)
  );

  // Day rollover has no consumer.
  bcd_counter #(.MAX(HR_MAX)) u_hr (
    .clk        (clk),
    .reset      (reset),
    .inc        (min_carry),
    .load       (load_hr),
    .load_value (set_value),
    .value      (hours_bcd),
    .carry_out  (hr_carry_unused)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      set_ready_q <= 1'b0;
      set_err_q   <= 1'b0;
      sec_pulse_q <= 1'b0;
    end else begin
      set_ready_q <= ~accept;
      set_err_q   <= accept & ~set_ok;
      sec_pulse_q <= tick;
    end
  end

  assign set_ready = set_ready_q;
  assign set_err   = set_err_q;
  assign sec_pulse = sec_pulse_q;

endmodule

// File: tb/tb_time_keeper.sv
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       reset;
  logic       sec_clk;
  logic       pause;
  logic       set_valid;
  logic [1:0] set_field;
  logic [7:0] set_value;
  logic       set_ready;
  logic       set_err;
  logic [7:0] seconds_bcd, minutes_bcd, hours_bcd;
  logic       sec_pulse;

  int total = 0;
  int bad   = 0;
  int npulse = 0;

  time_keeper dut (
    .clk         (clk),
    .reset       (reset),
    .sec_clk     (sec_clk),
    .pause       (pause),
    .set_valid   (set_valid),
    .set_field   (set_field),
    .set_value   (set_value),
    .set_ready   (set_ready),
    .set_err     (set_err),
    .seconds_bcd (seconds_bcd),
    .minutes_bcd (minutes_bcd),
    .hours_bcd   (hours_bcd),
    .sec_pulse   (sec_pulse)
  );

  always #10 clk = ~clk;

  // ---------------- behavioural model (decimal time of day) ----------------
  int m_s, m_m, m_h;
  bit m_err, m_pulse, m_ready;
  bit smp1, smp2, smp3;   // sec_clk samples taken 1, 2, 3 edges ago

  function automatic bit field_ok(input logic [1:0] f, input logic [7:0] v);
    int t, u, lim;
    t   = int'(v[7:4]);
    u   = int'(v[3:0]);
    lim = (f == 2'd2) ? 23 : 59;
    return (f != 2'd3) && (t <= 9) && (u <= 9) && (t * 10 + u <= lim);
  endfunction

  function automatic logic [7:0] to_bcd(input int x);
    logic [7:0] r;
    r[7:4] = 4'((x / 10) % 10);
    r[3:0] = 4'(x % 10);
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin : model
    bit tk, acc, ok, c;
    int ld, dec;
    if (!reset) begin
      m_s = 0; m_m = 0; m_h = 0;
      m_err = 0; m_pulse = 0; m_ready = 0;
      smp1 = 0; smp2 = 0; smp3 = 0;
    end else begin
      // A rise first sampled two edges ago is applied on this edge.
      tk  = smp2 && !smp3 && !pause;
      acc = set_valid && m_ready;
      ok  = acc && field_ok(set_field, set_value);
      ld  = ok ? int'(set_field) : -1;
      dec = int'(set_value[7:4]) * 10 + int'(set_value[3:0]);
      c   = 0;
      if (tk) begin
        if (ld != 0) begin
          m_s = m_s + 1;
          if (m_s == 60) begin m_s = 0; c = 1; end
        end
        if (c && ld != 1) begin
          c = 0;
          m_m = m_m + 1;
          if (m_m == 60) begin m_m = 0; c = 1; end
        end else begin
          c = 0;
        end
        if (c && ld != 2) m_h = (m_h + 1) % 24;
      end
      if (ld == 0) m_s = dec;
      if (ld == 1) m_m = dec;
      if (ld == 2) m_h = dec;
      m_err   = acc && !ok;
      m_pulse = tk;
      m_ready = !acc;
      smp3 = smp2; smp2 = smp1; smp1 = sec_clk;
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  always @(negedge clk) begin
    total++;
    if ({hours_bcd, minutes_bcd, seconds_bcd} !== {to_bcd(m_h), to_bcd(m_m), to_bcd(m_s)}) begin
      bad++;
      $display("FAIL time @%0t: got %h:%h:%h want %h:%h:%h", $time,
               hours_bcd, minutes_bcd, seconds_bcd, to_bcd(m_h), to_bcd(m_m), to_bcd(m_s));
    end
    total++;
    if ({sec_pulse, set_err, set_ready} !== {m_pulse, m_err, m_ready}) begin
      bad++;
      $display("FAIL flags @%0t: got pulse/err/ready=%b%b%b want %b%b%b", $time,
               sec_pulse, set_err, set_ready, m_pulse, m_err, m_ready);
    end
    if (sec_pulse === 1'b1) npulse++;
  end

  // ---------------- directed stimulus with literal expectations -----------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_set(input logic [1:0] f, input logic [7:0] v);
    @(negedge clk);
    set_valid = 1'b1; set_field = f; set_value = v;
    @(negedge clk);
    set_valid = 1'b0;
  endtask

  task automatic sec_rise();
    @(negedge clk); sec_clk = 1'b1;
    cycles(4);
    sec_clk = 1'b0;
    cycles(4);
  endtask

  int p0;

  initial begin
    reset = 1'b0; sec_clk = 1'b1; pause = 1'b0;
    set_valid = 1'b0; set_field = 2'd0; set_value = 8'h00;
    cycles(3);
    chk("reset_ready", int'(set_ready), 0);
    chk("reset_time", int'({hours_bcd, minutes_bcd, seconds_bcd}), 0);

    // Release with sec_clk already high: exactly one tick.
    reset = 1'b1;
    cycles(6);
    chk("release_tick_sec", int'(seconds_bcd), 'h01);
    chk("release_tick_count", npulse, 1);
    chk("ready_out_of_reset", int'(set_ready), 1);
    sec_clk = 1'b0;
    cycles(3);

    // Full rollover with exact N+2 timing.
    do_set(2'd2, 8'h23);
    do_set(2'd1, 8'h59);
    do_set(2'd0, 8'h59);
    cycles(1);
    chk("set_235959", int'({hours_bcd, minutes_bcd, seconds_bcd}), 'h235959);
    p0 = npulse;
    sec_clk = 1'b1;              // first sampled at edge N
    cycles(2);                   // after N+1
    chk("roll_before_n2", int'(hours_bcd), 'h23);
    cycles(1);                   // after N+2
    chk("roll_at_n2", int'({hours_bcd, minutes_bcd, seconds_bcd}), 0);
    chk("roll_pulse_hi", int'(sec_pulse), 1);
    cycles(1);                   // after N+3
    chk("roll_pulse_lo", int'(sec_pulse), 0);
    sec_clk = 1'b0;
    cycles(4);
    chk("roll_one_pulse", npulse - p0, 1);

    // Rejected sets.
    do_set(2'd2, 8'h24);
    chk("err_hr24", int'(set_err), 1);
    chk("err_hr24_hold", int'(hours_bcd), 0);
    cycles(1);
    chk("err_one_cycle", int'(set_err), 0);
    do_set(2'd2, 8'h1A);
    chk("err_digit", int'(set_err), 1);
    do_set(2'd3, 8'h05);
    chk("err_rsvd", int'(set_err), 1);
    cycles(1);
    chk("err_no_update", int'({hours_bcd, minutes_bcd, seconds_bcd}), 0);

    // Minutes set on the tick cycle: seconds wrap, carry into minutes dropped.
    do_set(2'd0, 8'h59);
    cycles(1);
    sec_clk = 1'b1;
    cycles(2);
    set_valid = 1'b1; set_field = 2'd1; set_value = 8'h30;
    cycles(1);
    set_valid = 1'b0;
    chk("carry_drop", int'({hours_bcd, minutes_bcd, seconds_bcd}), 'h003000);
    chk("carry_drop_pulse", int'(sec_pulse), 1);
    cycles(2);
    sec_clk = 1'b0;
    cycles(4);

    // Pause drops ticks; first rise after resume counts once.
    p0 = npulse;
    pause = 1'b1;
    repeat (3) sec_rise();
    chk("pause_time", int'({hours_bcd, minutes_bcd, seconds_bcd}), 'h003000);
    chk("pause_no_pulse", npulse - p0, 0);
    pause = 1'b0;
    sec_rise();
    chk("resume_time", int'({hours_bcd, minutes_bcd, seconds_bcd}), 'h003001);
    chk("resume_pulse", npulse - p0, 1);

    // Back-to-back requests.
    @(negedge clk);
    set_valid = 1'b1; set_field = 2'd0; set_value = 8'h10;
    cycles(1);
    chk("b2b_first", int'(seconds_bcd), 'h10);
    chk("b2b_ready_low", int'(set_ready), 0);
    set_value = 8'h20;
    cycles(1);
    chk("b2b_held", int'(seconds_bcd), 'h10);
    chk("b2b_ready_back", int'(set_ready), 1);
    cycles(1);
    set_valid = 1'b0;
    chk("b2b_second", int'(seconds_bcd), 'h20);

    // Rejected set coincident with a tick: tick still applies.
    cycles(2);
    sec_clk = 1'b1;
    cycles(2);
    set_valid = 1'b1; set_field = 2'd3; set_value = 8'h00;
    cycles(1);
    set_valid = 1'b0;
    chk("rej_tick_sec", int'(seconds_bcd), 'h21);
    chk("rej_tick_err", int'(set_err), 1);
    cycles(2);
    sec_clk = 1'b0;
    cycles(3);

    // Asynchronous reset mid-cycle clears without a clock edge.
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("async_time", int'({hours_bcd, minutes_bcd, seconds_bcd}), 0);
    chk("async_ready", int'(set_ready), 0);
    cycles(2);
    reset = 1'b1;
    cycles(4);
    chk("after_reset_idle", int'(seconds_bcd), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
